sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Two-port arbiter that shares the single sram_controller between the CPU instruction-fetch port (port 0) and the load/store data port (port 1).
- Accepts one request at a time and sequences the controller's read_op/write_op, address, write data and byte mask for ACCESS_CYCLES cycles.
- Registers the read word and returns it with a one-cycle ack pulse to the granted port.
- Sits between the pipeline's memory stages and sram_controller. It is the only driver of the controller's bus side.

Parameters:
ACCESS_CYCLES, 2, cycles read_op/write_op are held asserted per access (>=1); controller read data is valid in the last one
STARVE_LIMIT, 4, consecutive data-port grants allowed while ifetch is waiting before ifetch is forced (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
if_req  in  1  ifetch request, held until if_ack
if_addr  in  Ram_addr_t  ifetch word address
if_ack  out  1  one-cycle completion pulse for ifetch
if_rdata  out  Word_t  fetched word, valid when if_ack=1
d_req  in  1  data request, held until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  Ram_addr_t  data word address
d_wdata  in  Word_t  write data
d_be  in  4  byte enable, active high (1111 = word)
d_ack  out  1  one-cycle completion pulse for data
d_rdata  out  Word_t  load word, valid when d_ack=1
read_op  out  Bit_t  to controller
write_op  out  Bit_t  to controller
bus_addr  out  Ram_addr_t  to controller
bus_data_write  out  Word_t  to controller
byte_mask  out  4  to controller
bus_data_read  in  Word_t  from controller

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; read_op=write_op=0; bus_addr, bus_data_write=0; byte_mask=4'b0000.
  - if_ack=d_ack=0; if_rdata=d_rdata=0; beat counter=0; starve counter=0.
  - Reset mid-access abandons the access with no ack. A write in flight may or may not have reached SRAM.
- All controller-side outputs are registered.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Sample if_req and d_req.
  - Winner:
    - data if d_req and not (if_req and starve_cnt==STARVE_LIMIT);
    - else ifetch if if_req;
    - else stay in IDLE.
  - On a grant:
    - latch grant id, addr, we, wdata, be;
    - ifetch forces we=0 and be=1111;
    - go to ACCESS with beat=0.
- ACCESS:
  - Drive read_op=~we and write_op=we, plus the latched addr, wdata and byte_mask, for exactly ACCESS_CYCLES cycles. Beat counts 0..ACCESS_CYCLES-1.
  - On the last beat (read only), capture bus_data_read into the granted port's rdata register.
  - Go to RESP. read_op and write_op drop to 0 on entry to RESP.
- RESP:
  - Assert the granted port's ack for one cycle; the other ack stays 0.
  - Go to IDLE.
  - For a write, the granted port's rdata keeps its prior value.
- Latency: request sampled in IDLE at cycle t -> ack at cycle t+ACCESS_CYCLES+1. Back-to-back accesses have a period of ACCESS_CYCLES+2.
- Handshake:
  - Requester holds req, addr and data stable until it sees ack, then may drop req or present a new request in the following cycle.
  - req is never sampled outside IDLE. Changes to the inputs during ACCESS have no effect because the values are latched.
- Starvation counter:
  - On a data grant while if_req=1: increment, saturating at STARVE_LIMIT.
  - On any ifetch grant: clear.
  - On a data grant while if_req=0: clear.
- Simultaneous requests in IDLE: data wins unless starve_cnt==STARVE_LIMIT.
- rdata registers hold their value until the next completed read for that port.

Decomposition:
- Shared package:
  - Ram_addr_t, Word_t, Bit_t (existing);
  - new enum Arb_state_t {IDLE, ACCESS, RESP};
  - constant BYTE_MASK_WORD=4'b1111.
- No sub-module. A single flat FSM with the beat and starve counters.
- Bench: instantiate with sram_controller and fake_sram.

Test Plan:
1. Reset, then if_req=1 with if_addr=0x10 preloaded with 0xDEADBEEF -> read_op high for 2 cycles; if_ack pulses at t+3 with if_rdata=0xDEADBEEF; d_ack stays 0.
2. d_req write: addr 0x20, data 0x12345678, be=1111 -> write_op high for 2 cycles and d_ack at t+3. A following data read of 0x20 returns 0x12345678.
3. Byte write: d_be=0001 with data 0x000000AA to 0x20 (holding 0x12345678) -> byte_mask=0001 on the bus; readback is 0x123456AA.
4. if_req and d_req both high in the same cycle -> data is served first (d_ack at t+3); ifetch is granted in the next IDLE with if_ack at t+7.
5. d_req held continuously (new address each ack) with if_req high -> exactly 4 data acks, then an if_ack, then data resumes.
6. rst asserted during ACCESS of a read -> next cycle read_op=0 and no ack; after rst release, a new request completes normally with correct data.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter and its controller-side bus.
package sram_arbiter_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef logic [ADDR_W-1:0] Ram_addr_t;
  typedef logic [WORD_W-1:0] Word_t;
  typedef logic              Bit_t;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} Arb_state_t;

  localparam logic [BE_W-1:0] BYTE_MASK_WORD = 4'b1111;

  // Request as latched onto the controller bus at grant time
  typedef struct packed {
    Ram_addr_t       addr;
    Word_t           wdata;
    logic [BE_W-1:0] be;
    logic            we;
  } Bus_req_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one SRAM controller between ifetch (port 0) and data (port 1).
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  Ram_addr_t       if_addr,
  output logic            if_ack,
  output Word_t           if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  Ram_addr_t       d_addr,
  input  Word_t           d_wdata,
  input  logic [BE_W-1:0] d_be,
  output logic            d_ack,
  output Word_t           d_rdata,
  output Bit_t            read_op,
  output Bit_t            write_op,
  output Ram_addr_t       bus_addr,
  output Word_t           bus_data_write,
  output logic [BE_W-1:0] byte_mask,
  input  Word_t           bus_data_read
);

  localparam int unsigned BEAT_W   = $clog2(ACCESS_CYCLES + 1);
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  Arb_state_t          state, state_nx;
  logic [BEAT_W-1:0]   beat, beat_nx;
  logic [STARVE_W-1:0] starve, starve_nx;
  logic                grant, grant_nx;
  logic                data_win;
  Bus_req_t            sel;

  Bit_t            read_op_nx, write_op_nx;
  Ram_addr_t       bus_addr_nx;
  Word_t           bus_data_write_nx, if_rdata_nx, d_rdata_nx;
  logic [BE_W-1:0] byte_mask_nx;
  logic            if_ack_nx, d_ack_nx;

  // Data wins unless ifetch has waited through STARVE_LIMIT data grants
  assign data_win = d_req && !(if_req && (starve == STARVE_W'(STARVE_LIMIT)));

  always_comb begin
    sel = data_win ? '{addr: d_addr, wdata: d_wdata, be: d_be, we: d_we}
                   : '{addr: if_addr, wdata: bus_data_write, be: BYTE_MASK_WORD, we: 1'b0};
  end

  always_comb begin
    state_nx          = state;
    beat_nx           = beat;
    starve_nx         = starve;
    grant_nx          = grant;
    read_op_nx        = read_op;
    write_op_nx       = write_op;
    bus_addr_nx       = bus_addr;
    bus_data_write_nx = bus_data_write;
    byte_mask_nx      = byte_mask;
    if_ack_nx         = 1'b0;
    d_ack_nx          = 1'b0;
    if_rdata_nx       = if_rdata;
    d_rdata_nx        = d_rdata;

    unique case (state)
      IDLE: begin
        if (d_req || if_req) begin
          state_nx          = ACCESS;
          beat_nx           = '0;
          grant_nx          = data_win;
          bus_addr_nx       = sel.addr;
          bus_data_write_nx = sel.wdata;
          byte_mask_nx      = sel.be;
          read_op_nx        = ~sel.we;
          write_op_nx       = sel.we;
          // data_win with if_req pending implies starve < STARVE_LIMIT, so this saturates
          starve_nx         = (data_win && if_req) ? starve + STARVE_W'(1) : '0;
        end
      end
      ACCESS: begin
        if (beat == BEAT_W'(ACCESS_CYCLES - 1)) begin
          state_nx    = RESP;
          read_op_nx  = 1'b0;
          write_op_nx = 1'b0;
          if_ack_nx   = ~grant;
          d_ack_nx    = grant;
          if (read_op) begin
            if (grant) d_rdata_nx  = bus_data_read;
            else       if_rdata_nx = bus_data_read;
          end
        end else begin
          beat_nx = beat + BEAT_W'(1);
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      beat           <= '0;
      starve         <= '0;
      grant          <= 1'b0;
      read_op        <= 1'b0;
      write_op       <= 1'b0;
      bus_addr       <= '0;
      bus_data_write <= '0;
      byte_mask      <= '0;
      if_ack         <= 1'b0;
      d_ack          <= 1'b0;
      if_rdata       <= '0;
      d_rdata        <= '0;
    end else begin
      state          <= state_nx;
      beat           <= beat_nx;
      starve         <= starve_nx;
      grant          <= grant_nx;
      read_op        <= read_op_nx;
      write_op       <= write_op_nx;
      bus_addr       <= bus_addr_nx;
      bus_data_write <= bus_data_write_nx;
      byte_mask      <= byte_mask_nx;
      if_ack         <= if_ack_nx;
      d_ack          <= d_ack_nx;
      if_rdata       <= if_rdata_nx;
      d_rdata        <= d_rdata_nx;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM behind the controller bus.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int AC = 2;
  localparam int SL = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_mem;
  logic            if_req, d_req, d_we;
  Ram_addr_t       if_addr, d_addr;
  Word_t           d_wdata;
  logic [3:0]      d_be;
  logic            if_ack, d_ack;
  Word_t           if_rdata, d_rdata;
  Bit_t            read_op, write_op;
  Ram_addr_t       bus_addr;
  Word_t           bus_data_write, bus_data_read;
  logic [3:0]      byte_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .read_op(read_op), .write_op(write_op), .bus_addr(bus_addr),
    .bus_data_write(bus_data_write), .byte_mask(byte_mask), .bus_data_read(bus_data_read)
  );

  // SRAM model: read data only valid on the last cycle of a read access
  Word_t mem [0:1023];
  int    rd_cnt = 0;

  always @(posedge clk) begin
    rd_cnt <= read_op ? rd_cnt + 1 : 0;
    if (load_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem[10'h010] <= 32'hDEADBEEF;
      mem[10'h024] <= 32'h11223344;
      mem[10'h030] <= 32'hCAFEF00D;
      for (int k = 0; k < 8; k++) mem[10'h100 + 10'(k)] <= 32'hA0000000 + 32'(k);
    end else if (write_op) begin
      for (int b = 0; b < 4; b++)
        if (byte_mask[b]) mem[bus_addr[9:0]][8*b +: 8] <= bus_data_write[8*b +: 8];
    end
  end

  assign bus_data_read = (read_op && rd_cnt == AC - 1) ? mem[bus_addr[9:0]] : 32'h0;

  typedef struct {
    logic       port;
    logic       we;
    Ram_addr_t  addr;
    Word_t      wdata;
    logic [3:0] be;
    Word_t      exp_rdata;
    logic [3:0] exp_mask;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE (called at a negedge) and check the whole access
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0, rd = 0, wr = 0;
    logic got_if = 1'b0, got_d = 1'b0;
    logic [3:0] mask_seen = 4'h0;
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    while (!got_if && !got_d && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (read_op)  rd++;
      if (write_op) wr++;
      if (read_op || write_op) mask_seen = byte_mask;
      got_if = if_ack;
      got_d  = d_ack;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    chk($sformatf("v%0d ack_port", idx), {30'b0, got_d, got_if}, v.port ? 32'd2 : 32'd1);
    chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(AC + 1));
    chk($sformatf("v%0d read_op_cycles", idx), 32'(rd), (v.port && v.we) ? 32'd0 : 32'(AC));
    chk($sformatf("v%0d write_op_cycles", idx), 32'(wr), (v.port && v.we) ? 32'(AC) : 32'd0);
    chk($sformatf("v%0d byte_mask", idx), {28'b0, mask_seen}, {28'b0, v.exp_mask});
    chk($sformatf("v%0d rdata", idx), v.port ? d_rdata : if_rdata, v.exp_rdata);
    @(negedge clk);
  endtask

  initial begin
    int dc, ic, n, k, cyc, acks;
    logic [5:0] order;
    int ack_cyc [6];
    vec_t rv;

    vecs[0] = '{port:1'b0, we:1'b0, addr:16'h0010, wdata:32'h0,        be:4'hF, exp_rdata:32'hDEADBEEF, exp_mask:4'hF};
    vecs[1] = '{port:1'b1, we:1'b1, addr:16'h0020, wdata:32'h12345678, be:4'hF, exp_rdata:32'h00000000, exp_mask:4'hF};
    vecs[2] = '{port:1'b1, we:1'b0, addr:16'h0020, wdata:32'h0,        be:4'hF, exp_rdata:32'h12345678, exp_mask:4'hF};
    vecs[3] = '{port:1'b1, we:1'b1, addr:16'h0020, wdata:32'h000000AA, be:4'h1, exp_rdata:32'h12345678, exp_mask:4'h1};
    vecs[4] = '{port:1'b1, we:1'b0, addr:16'h0020, wdata:32'h0,        be:4'hF, exp_rdata:32'h123456AA, exp_mask:4'hF};
    vecs[5] = '{port:1'b1, we:1'b1, addr:16'h0024, wdata:32'hAABBCCDD, be:4'hC, exp_rdata:32'h123456AA, exp_mask:4'hC};
    vecs[6] = '{port:1'b1, we:1'b0, addr:16'h0024, wdata:32'h0,        be:4'hF, exp_rdata:32'hAABB3344, exp_mask:4'hF};
    vecs[7] = '{port:1'b0, we:1'b0, addr:16'h0024, wdata:32'h0,        be:4'hF, exp_rdata:32'hAABB3344, exp_mask:4'hF};
    vecs[8] = '{port:1'b1, we:1'b0, addr:16'h0010, wdata:32'h0,        be:4'hF, exp_rdata:32'hDEADBEEF, exp_mask:4'hF};

    rst = 1'b1; load_mem = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset ops_acks", {28'b0, read_op, write_op, if_ack, d_ack}, 32'h0);
    chk("reset bus_addr", {16'b0, bus_addr}, 32'h0);
    chk("reset bus_data_write", bus_data_write, 32'h0);
    chk("reset byte_mask", {28'b0, byte_mask}, 32'h0);
    chk("reset if_rdata", if_rdata, 32'h0);
    chk("reset d_rdata", d_rdata, 32'h0);
    rst = 1'b0; load_mem = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Simultaneous requests: data first, ifetch in the following IDLE
    dc = 0; ic = 0; cyc = 0;
    if_req = 1'b1; if_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    while (ic == 0 && cyc < 16) begin
      @(negedge clk);
      cyc++;
      if (d_ack) begin
        dc = cyc; d_req = 1'b0;
        chk("simul d_rdata", d_rdata, 32'h123456AA);
      end
      if (if_ack) begin
        ic = cyc; if_req = 1'b0;
        chk("simul if_rdata", if_rdata, 32'hDEADBEEF);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("simul d_ack cycle", 32'(dc), 32'(AC + 1));
    chk("simul if_ack cycle", 32'(ic), 32'(2 * AC + 3));
    @(negedge clk);

    // Continuous data traffic: ifetch forced after SL data grants
    n = 0; k = 0; cyc = 0; order = '0;
    for (int j = 0; j < 6; j++) ack_cyc[j] = 0;
    if_req = 1'b1; if_addr = 16'h0030;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    while (n < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (d_ack) begin
        chk($sformatf("starve d_rdata%0d", k), d_rdata, 32'hA0000000 + 32'(k));
        k++;
        order[n] = 1'b1; ack_cyc[n] = cyc; n++;
        if (n < 6) d_addr = 16'h0100 + 16'(k);
        else       d_req = 1'b0;
      end
      if (if_ack && n < 6) begin
        chk("starve if_rdata", if_rdata, 32'hCAFEF00D);
        order[n] = 1'b0; ack_cyc[n] = cyc; n++;
        if_req = 1'b0;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("starve ack count", 32'(n), 32'd6);
    chk("starve ack order", {26'b0, order}, 32'h2F);
    chk("starve if_ack cycle", 32'(ack_cyc[4]), 32'(SL * (AC + 2) + AC + 1));
    repeat (AC + 3) @(negedge clk);

    // Reset during the ACCESS phase of a read
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    @(negedge clk);
    chk("rst_mid read_op before", {31'b0, read_op}, 32'd1);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("rst_mid read_op after", {31'b0, read_op}, 32'd0);
    chk("rst_mid d_rdata", d_rdata, 32'h0);
    rst = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_ack || d_ack) acks++;
    end
    chk("rst_mid no ack", 32'(acks), 32'd0);
    rv = '{port:1'b1, we:1'b0, addr:16'h0024, wdata:32'h0, be:4'hF, exp_rdata:32'hAABB3344, exp_mask:4'hF};
    run_vec(rv, 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
